dm_bytelane: RTL and testbench

- Parametrised successor to the pipeline's word-only data memory, instantiated in the MEM stage.
- Adds a request/response handshake and a one-cycle registered read.
- Supports sub-word loads and stores: LB/LBU/LH/LHU/SB/SH, plus unaligned LWL/LWR/SWL/SWR (little-endian MIPS).
- Adds a hardware clear sequencer that zeroes the array after reset.

---
 rtl/dm_pkg.sv | 11 +
 rtl/dm_lane_align.sv | 51 +++++
 rtl/dm_bytelane.sv | 88 ++++++++
 tb/tb_dm_bytelane.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: op encodings and clear/run FSM states shared by the byte-lane data memory
package dm_pkg;
  localparam logic [2:0] DM_OP_W  = 3'd0;
  localparam logic [2:0] DM_OP_H  = 3'd1;
  localparam logic [2:0] DM_OP_HU = 3'd2;
  localparam logic [2:0] DM_OP_B  = 3'd3;
  localparam logic [2:0] DM_OP_BU = 3'd4;
  localparam logic [2:0] DM_OP_WL = 3'd5;
  localparam logic [2:0] DM_OP_WR = 3'd6;
  typedef enum logic {ST_CLEAR, ST_RUN} dm_state_t;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: store byte-enables/data shifting and load extract/extend/merge (little-endian)
// Ports: op, k (byte offset), wdata (store rt), rt (load merge rt), word (memory word)
//        -> be (byte enables), sdata (lane-aligned store data), rdata (load result)
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  k,
  input  logic [31:0] wdata,
  input  logic [31:0] rt,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] sdata,
  output logic [31:0] rdata
);
  logic [4:0]  shl, shr;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    shl = {~k, 3'b000};
    shr = {k, 3'b000};
    b = 8'(word >> shr);
    h = k[1] ? word[31:16] : word[15:0];
    be = 4'b1111;
    sdata = wdata;
    rdata = word;
    case (op)
      DM_OP_B, DM_OP_BU: begin
        be = 4'b0001 << k;
        sdata = {4{wdata[7:0]}};
        rdata = op == DM_OP_B ? {{24{b[7]}}, b} : {24'b0, b};
      end
      DM_OP_H, DM_OP_HU: begin
        be = k[1] ? 4'b1100 : 4'b0011;
        sdata = {2{wdata[15:0]}};
        rdata = op == DM_OP_H ? {{16{h[15]}}, h} : {16'b0, h};
      end
      DM_OP_WL: begin
        be = 4'b1111 >> ~k;
        sdata = wdata >> shl;
        rdata = (word << shl) | (rt & ~(32'hFFFF_FFFF << shl));
      end
      DM_OP_WR: begin
        be = 4'b1111 << k;
        sdata = wdata << shr;
        rdata = (word >> shr) | (rt & ~(32'hFFFF_FFFF >> shr));
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dm_bytelane.sv
// dm_bytelane: MEM-stage data memory with handshake, sub-word/unaligned access and clear-after-reset
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_we/req_op/req_addr/req_wdata/req_rt
//        request; rsp_valid/rsp_rdata one-cycle load response; busy while clearing; addr_err.
// Optional: DM_ALIGN_CHECK_EN flags and suppresses misaligned H/W accesses (else addr_err tied 0).
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        addr_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [31:0] mem [DEPTH];
  dm_state_t state, state_n;
  logic [ADDR_W-1:0] clr_idx, widx;
  logic [1:0] k;
  logic acc, mis, addr_unused;
  logic [3:0] be;
  logic [31:0] sdata, ld;
  assign widx = req_addr[ADDR_W+1:2];
  assign k = req_addr[1:0];
  assign addr_unused = ^req_addr[31:ADDR_W+2];
  always_comb begin
    busy = state == ST_CLEAR;
    req_ready = state == ST_RUN;
    state_n = busy && clr_idx == '1 ? ST_RUN : state;
    acc = req_valid && req_ready;
  end
  dm_lane_align u_align (
    .op(req_op),
    .k(k),
    .wdata(req_wdata),
    .rt(req_rt),
    .word(mem[widx]),
    .be(be),
    .sdata(sdata),
    .rdata(ld)
  );
`ifdef DM_ALIGN_CHECK_EN
  assign mis = ((req_op == DM_OP_H || req_op == DM_OP_HU) && k[0]) ||
               ((req_op == DM_OP_W || req_op == 3'd7) && k != 2'd0);
  always_ff @(posedge clk)
    addr_err <= reset ? 1'b0 : acc && mis;
`else
  assign mis = 1'b0;
  assign addr_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      clr_idx <= busy ? clr_idx + 1'b1 : clr_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy)
        mem[clr_idx] <= '0;
      else if (acc && req_we && !mis)
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[widx][8*i +: 8] <= sdata[8*i +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= acc && !req_we;
      if (acc && !req_we) rsp_rdata <= mis ? '0 : ld;
    end
  end
endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: directed self-checking bench for dm_bytelane (ADDR_W=4)
module tb_dm_bytelane;
  import dm_pkg::*;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_rt = '0;
  logic req_ready, rsp_valid, busy, addr_err;
  logic [31:0] rsp_rdata;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dm_bytelane #(.ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_rt(req_rt),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy(busy),
    .addr_err(addr_err)
  );
  task automatic drive(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rt);
    req_valid = 1'b1;
    req_we = we;
    req_op = op;
    req_addr = addr;
    req_wdata = wdata;
    req_rt = rt;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic count_busy(output int n, output int rdy);
    n = 0;
    rdy = 0;
    while (busy && n < 100) begin
      n++;
      if (req_ready) rdy++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    int n, rdy;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, req_ready, rsp_valid, addr_err} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=1000", {busy, req_ready, rsp_valid, addr_err});
    end
    total++;
    if (rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata got=%h want=00000000", rsp_rdata);
    end
    reset = 1'b0;
    count_busy(n, rdy);
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL clear_cycles got=%0d want=16", n);
    end
    total++;
    if (rdy !== 0) begin
      bad++;
      $display("FAIL ready_while_busy got=%0d want=0", rdy);
    end
    total++;
    if ({busy, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL run_flags got=%b want=01", {busy, req_ready});
    end
  endtask
  task automatic test_clear_contents;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, DM_OP_W, 32'(i * 4), 32'h0, 32'h0);
      total++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin
        bad++;
        $display("FAIL clear_word%0d got=%b/%h want=1/00000000", i, rsp_valid, rsp_rdata);
      end
    end
  endtask
  task automatic test_reset_mid_clear;
    int n, rdy;
    drive(1'b1, DM_OP_W, 32'h3C, 32'hDEADBEEF, 32'h0);
    drive(1'b1, DM_OP_W, 32'h0C, 32'h12345678, 32'h0);
    drive(1'b0, DM_OP_W, 32'h3C, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL seed_word15 got=%h want=deadbeef", rsp_rdata);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_clear_busy got=%b want=1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(n, rdy);
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL restart_cycles got=%0d want=16", n);
    end
    drive(1'b0, DM_OP_W, 32'h3C, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL restart_word15 got=%h want=00000000", rsp_rdata);
    end
    drive(1'b0, DM_OP_W, 32'h0C, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL restart_word3 got=%h want=00000000", rsp_rdata);
    end
  endtask
  task automatic test_subword_load;
    logic [2:0] ops [4] = '{DM_OP_B, DM_OP_BU, DM_OP_H, DM_OP_HU};
    logic [31:0] adr [4] = '{32'h11, 32'h11, 32'h12, 32'h10};
    logic [31:0] exp [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABC};
    drive(1'b1, DM_OP_W, 32'h10, 32'h8899AABC, 32'h0);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL store_no_rsp got=%b want=0", rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ops[i], adr[i], 32'h0, 32'h0);
      total++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL subload%0d got=%b/%h want=1/%h", i, rsp_valid, rsp_rdata, exp[i]);
      end
    end
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h0000AABC}) begin
      bad++;
      $display("FAIL rdata_hold got=%b/%h want=0/0000aabc", rsp_valid, rsp_rdata);
    end
  endtask
  task automatic test_subword_store;
    drive(1'b1, DM_OP_W, 32'h20, 32'h11223344, 32'h0);
    drive(1'b1, DM_OP_B, 32'h22, 32'h000000EE, 32'h0);
    drive(1'b0, DM_OP_W, 32'h20, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'h11EE3344) begin
      bad++;
      $display("FAIL sb got=%h want=11ee3344", rsp_rdata);
    end
    drive(1'b1, DM_OP_H, 32'h20, 32'h0000BEEF, 32'h0);
    drive(1'b0, DM_OP_W, 32'h20, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'h11EEBEEF) begin
      bad++;
      $display("FAIL sh got=%h want=11eebeef", rsp_rdata);
    end
  endtask
  task automatic test_unaligned;
    drive(1'b1, DM_OP_W, 32'h30, 32'h44332211, 32'h0);
    drive(1'b0, DM_OP_WL, 32'h31, 32'h0, 32'hAABBCCDD);
    total++;
    if (rsp_rdata !== 32'h2211CCDD) begin
      bad++;
      $display("FAIL lwl got=%h want=2211ccdd", rsp_rdata);
    end
    drive(1'b0, DM_OP_WR, 32'h31, 32'h0, 32'hAABBCCDD);
    total++;
    if (rsp_rdata !== 32'hAA443322) begin
      bad++;
      $display("FAIL lwr got=%h want=aa443322", rsp_rdata);
    end
    drive(1'b1, DM_OP_WL, 32'h31, 32'hAABBCCDD, 32'h0);
    drive(1'b0, DM_OP_W, 32'h30, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'h4433AABB) begin
      bad++;
      $display("FAIL swl got=%h want=4433aabb", rsp_rdata);
    end
    drive(1'b1, DM_OP_W, 32'h30, 32'h44332211, 32'h0);
    drive(1'b1, DM_OP_WR, 32'h31, 32'hAABBCCDD, 32'h0);
    drive(1'b0, DM_OP_W, 32'h30, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'hBBCCDD11) begin
      bad++;
      $display("FAIL swr got=%h want=bbccdd11", rsp_rdata);
    end
  endtask
  task automatic test_back_to_back;
    drive(1'b1, DM_OP_W, 32'h40, 32'hCAFEF00D, 32'h0);
    drive(1'b0, DM_OP_W, 32'h40, 32'h0, 32'h0);
    total++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      bad++;
      $display("FAIL raw got=%b/%h want=1/cafef00d", rsp_valid, rsp_rdata);
    end
    drive(1'b1, DM_OP_W, 32'h40, 32'h0BADF00D, 32'h0);
    total++;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 32'hCAFEF00D}) begin
      bad++;
      $display("FAIL rsp_cycle_store got=%b/%h want=0/cafef00d", rsp_valid, rsp_rdata);
    end
    drive(1'b0, DM_OP_W, 32'h1000_0040, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL wrap_high got=%h want=0badf00d", rsp_rdata);
    end
    drive(1'b0, DM_OP_W, 32'h0, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL wrap_alias got=%h want=0badf00d", rsp_rdata);
    end
    drive(1'b1, DM_OP_W, 32'h40, 32'hCAFEF00D, 32'h0);
  endtask
  task automatic test_align;
    drive(1'b1, DM_OP_W, 32'h42, 32'h12345678, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
    total++;
    if ({addr_err, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL mis_store_err got=%b want=10", {addr_err, rsp_valid});
    end
    drive(1'b0, DM_OP_W, 32'h40, 32'h0, 32'h0);
    total++;
    if ({addr_err, rsp_rdata} !== {1'b0, 32'hCAFEF00D}) begin
      bad++;
      $display("FAIL mis_store_kept got=%b/%h want=0/cafef00d", addr_err, rsp_rdata);
    end
    drive(1'b0, DM_OP_H, 32'h41, 32'h0, 32'h0);
    total++;
    if ({addr_err, rsp_valid, rsp_rdata} !== {2'b11, 32'h0}) begin
      bad++;
      $display("FAIL mis_load got=%b%b/%h want=11/00000000", addr_err, rsp_valid, rsp_rdata);
    end
    drive(1'b0, DM_OP_WL, 32'h41, 32'h0, 32'h0);
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL lwl_not_mis got=%b want=0", addr_err);
    end
`else
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL err_tied got=%b want=0", addr_err);
    end
    drive(1'b0, DM_OP_W, 32'h40, 32'h0, 32'h0);
    total++;
    if (rsp_rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL forced_sw got=%h want=12345678", rsp_rdata);
    end
    drive(1'b0, DM_OP_H, 32'h41, 32'h0, 32'h0);
    total++;
    if ({addr_err, rsp_valid, rsp_rdata} !== {2'b01, 32'h00005678}) begin
      bad++;
      $display("FAIL forced_lh got=%b%b/%h want=01/00005678", addr_err, rsp_valid, rsp_rdata);
    end
`endif
  endtask
  initial begin
    test_reset;
    test_clear_contents;
    test_reset_mid_clear;
    test_subword_load;
    test_subword_store;
    test_unaligned;
    test_back_to_back;
    test_align;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
